// File: rtl/mem_defs.sv
// Shared definitions for the memory-stage controller: access codes, states,
// byte-enable patterns and the request legality check.
package mem_defs;

    localparam int unsigned DW = 32;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_ALL     = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Stores ignore op[2], so 110/111 only fail as loads; 111 also fails via size 11.
    function automatic logic op_legal(input logic is_load, input logic [2:0] op,
                                      input logic [1:0] lane);
        logic ok;
        ok = 1'b1;
        if (op[1:0] == 2'b11)                 ok = 1'b0;
        if (is_load && op[2] && op[1])        ok = 1'b0;
        if (op[1:0] == SZ_HALF && lane[0])    ok = 1'b0;
        if (op[1:0] == SZ_WORD && lane != 2'b00) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or
// zero-extends it to 32 bits.
module mem_load_align
    import mem_defs::*;
(
    input  logic [DW-1:0] rdata,
    input  logic [2:0]    op,
    input  logic [1:0]    lane,
    output logic [DW-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h000000, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: turns EX/MEM loads/stores into req/ack transactions,
// stalls the pipeline while outstanding and delivers aligned load data.
module mem_access_ctrl
    import mem_defs::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [2:0]    MemOp,
    input  logic [DW-1:0] Addr,
    input  logic [DW-1:0] WriteData,
    output logic          Stall,
    output logic [DW-1:0] LoadData,
    output logic          Done,
    output logic          AddrErr,
    output logic          BusErr,
    output logic          MemReq,
    output logic          MemWe,
    output logic [DW-1:0] MemAddr,
    output logic [3:0]    MemBE,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    input  logic          MemAck
);

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_e        state;
    logic [2:0]    op_q;
    logic [1:0]    lane_q;
    logic          is_load_q;
    logic [TW-1:0] cnt;

    logic          req_c;
    logic          legal_c;
    logic [2:0]    op_c;
    logic [3:0]    be_c;
    logic [DW-1:0] wdata_c;
    logic [DW-1:0] align_data;

    mem_load_align u_align (
        .rdata (MemRData),
        .op    (op_q),
        .lane  (lane_q),
        .data  (align_data)
    );

    // Request decode; a simultaneous read and write is treated as a load.
    always_comb begin
        req_c   = MemRead | MemWrite;
        op_c    = MemRead ? MemOp : {1'b0, MemOp[1:0]};
        legal_c = op_legal(MemRead, MemOp, Addr[1:0]);
        be_c    = BE_ALL;
        wdata_c = WriteData;
        if (!MemRead) begin
            case (op_c[1:0])
                SZ_BYTE: begin
                    be_c    = BE_BYTE0 << Addr[1:0];
                    wdata_c = {4{WriteData[7:0]}};
                end
                SZ_HALF: begin
                    be_c    = Addr[1] ? BE_HI_HALF : BE_LO_HALF;
                    wdata_c = {2{WriteData[15:0]}};
                end
                default: ;
            endcase
        end
        Stall = (state == ST_WAIT) || (state == ST_IDLE && req_c && legal_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            MemReq    <= 1'b0;
            MemWe     <= 1'b0;
            MemBE     <= BE_NONE;
            MemAddr   <= '0;
            MemWData  <= '0;
            Done      <= 1'b0;
            AddrErr   <= 1'b0;
            BusErr    <= 1'b0;
            LoadData  <= '0;
            op_q      <= 3'b000;
            lane_q    <= 2'b00;
            is_load_q <= 1'b0;
            cnt       <= '0;
        end else begin
            Done    <= 1'b0;
            AddrErr <= 1'b0;
            BusErr  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_c && legal_c) begin
                        state     <= ST_WAIT;
                        MemReq    <= 1'b1;
                        MemWe     <= ~MemRead;
                        MemAddr   <= {Addr[31:2], 2'b00};
                        MemBE     <= be_c;
                        MemWData  <= wdata_c;
                        op_q      <= op_c;
                        lane_q    <= Addr[1:0];
                        is_load_q <= MemRead;
                        cnt       <= '0;
                    end else if (req_c) begin
                        AddrErr <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (MemAck) begin
                        MemReq <= 1'b0;
                        Done   <= 1'b1;
                        state  <= ST_DONE;
                        if (is_load_q) LoadData <= align_data;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        MemReq <= 1'b0;
                        BusErr <= 1'b1;
                        state  <= ST_IDLE;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
